// File: rtl/cache_fill_fsm_if.sv
// Miss-handler bus bundle: cache-side miss request, memory read port and cache fill write port.
// master is the fill FSM; slave is the surrounding cache/memory environment.
interface cache_fill_fsm_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic [DATA_W-1:0] memory_data;
   logic              memory_data_valid;
   logic              fsm_busy;
   logic              memory_enable;
   logic [ADDR_W-1:0] memory_address;
   logic              write_data_array;
   logic              write_tag_array;
   logic [ADDR_W-1:0] cache_address;
   logic [DATA_W-1:0] cache_data;

   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, memory_enable, memory_address, write_data_array, write_tag_array,
             cache_address, cache_data
   );

   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, memory_enable, memory_address, write_data_array, write_tag_array,
             cache_address, cache_data
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one block from a pipelined memory into the data array,
// one request per cycle, then writes the tag alongside the last returned word.
module cache_fill_fsm #(
   parameter int unsigned BLOCK_WORDS = 8,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   cache_fill_fsm_if.master   bus_io
);

   localparam int unsigned IdxW  = $clog2(BLOCK_WORDS);
   localparam int unsigned CntW  = IdxW + 1;
   localparam int unsigned Off   = IdxW + 1;
   localparam int unsigned BaseW = ADDR_W - Off;

   localparam logic [CntW-1:0] BlockCnt = CntW'(BLOCK_WORDS);
   localparam logic [CntW-1:0] LastCnt  = CntW'(BLOCK_WORDS - 1);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StFill = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [BaseW-1:0] base_q, base_d;
   logic [CntW-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CntW-1:0]  recv_cnt_q, recv_cnt_d;

   logic              busy;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic              wr_data;
   logic              wr_tag;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      busy        = 1'b0;
      mem_en      = 1'b0;
      mem_addr    = '0;
      wr_data     = 1'b0;
      wr_tag      = 1'b0;
      c_addr      = '0;
      c_data      = '0;
      case (state_q)
         StIdle: begin
            if (bus_io.miss_detected) begin
               busy    = 1'b1;
               base_d  = bus_io.miss_address[ADDR_W-1:Off];
               state_d = StFill;
            end
         end
         StFill: begin
            busy = 1'b1;
            if (issue_cnt_q < BlockCnt) begin
               mem_en      = 1'b1;
               mem_addr    = {base_q, issue_cnt_q[IdxW-1:0], 1'b0};
               issue_cnt_d = issue_cnt_q + CntW'(1);
            end
            // A return past the last word cannot happen; it is dropped rather than written.
            if (bus_io.memory_data_valid && (recv_cnt_q < BlockCnt)) begin
               wr_data    = 1'b1;
               c_addr     = {base_q, recv_cnt_q[IdxW-1:0], 1'b0};
               c_data     = bus_io.memory_data;
               recv_cnt_d = recv_cnt_q + CntW'(1);
               if (recv_cnt_q == LastCnt) begin
                  wr_tag      = 1'b1;
                  state_d     = StIdle;
                  issue_cnt_d = '0;
                  recv_cnt_d  = '0;
               end
            end
         end
         default: begin
            state_d     = StIdle;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
      end
   end

   // Stall is combinational from miss; hold it low while reset is asserted.
   assign bus_io.fsm_busy         = busy & rst_n;
   assign bus_io.memory_enable    = mem_en;
   assign bus_io.memory_address   = mem_addr;
   assign bus_io.write_data_array = wr_data;
   assign bus_io.write_tag_array  = wr_tag;
   assign bus_io.cache_address    = c_addr;
   assign bus_io.cache_data       = c_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed + randomized bench for cache_fill_fsm against a timing-formula model of one fill
// and a fixed-latency pipelined memory responder.
module tb_cache_fill_fsm;

   logic clk;
   logic rst_n;

   cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   cache_fill_fsm #(
      .BLOCK_WORDS(8),
      .ADDR_W     (16),
      .DATA_W     (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] d;
   } rsp_t;

   rsp_t        rq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          m_act = 0;
   int          t0 = 0;
   logic [11:0] mbase = '0;
   int          mlat = 1;
   logic [15:0] words[8];
   logic [15:0] nxt_words[8];
   int          nxt_lat = 1;
   int          n_wr, n_tag, n_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_counts();
      n_wr = 0; n_tag = 0; n_busy = 0;
   endtask

   task automatic rand_words();
      for (int i = 0; i < 8; i++) nxt_words[i] = 16'($urandom);
   endtask

   // One clock cycle: drive inputs at negedge, model and check at negedge+2, log requests.
   task automatic tick(input logic miss, input logic [15:0] maddr);
      int          r;
      logic        e_busy, e_en, e_wr, e_tag;
      logic [15:0] e_maddr, e_caddr;
      rsp_t        rs;
      @(negedge clk);
      bus.miss_detected = miss;
      bus.miss_address  = maddr;
      if (rst_n && !m_act && miss) begin
         m_act = 1; t0 = cyc; mbase = maddr[15:4]; mlat = nxt_lat; words = nxt_words;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
         bus.memory_data_valid = 1'b1;
         bus.memory_data       = rq[0].d;
         void'(rq.pop_front());
      end else begin
         bus.memory_data_valid = m_act ? 1'b0 : 1'($urandom_range(0, 1));
         bus.memory_data       = 16'($urandom);
      end
      #2;
      r       = cyc - t0;
      e_busy  = rst_n && m_act;
      e_en    = m_act && r >= 1 && r <= 8;
      e_wr    = m_act && r >= 1 + mlat && r <= 8 + mlat;
      e_tag   = m_act && r == 8 + mlat;
      e_maddr = e_en ? {mbase, 3'(r - 1), 1'b0} : 16'h0;
      e_caddr = e_wr ? {mbase, 3'(r - 1 - mlat), 1'b0} : 16'h0;
      chk("fsm_busy", 32'(bus.fsm_busy), 32'(e_busy));
      chk("memory_enable", 32'(bus.memory_enable), 32'(e_en));
      chk("write_data_array", 32'(bus.write_data_array), 32'(e_wr));
      chk("write_tag_array", 32'(bus.write_tag_array), 32'(e_tag));
      if (e_en || !m_act || r == 0) chk("memory_address", 32'(bus.memory_address), 32'(e_maddr));
      if (e_wr || !m_act || r == 0) chk("cache_address", 32'(bus.cache_address), 32'(e_caddr));
      if (e_wr) chk("cache_data", 32'(bus.cache_data), 32'(words[r - 1 - mlat]));
      if (bus.write_data_array) n_wr++;
      if (bus.write_tag_array) n_tag++;
      if (bus.fsm_busy) n_busy++;
      if (bus.memory_enable) begin
         rs.due = cyc + mlat;
         rs.d   = words[bus.memory_address[3:1]];
         rq.push_back(rs);
      end
      if (m_act && r == 8 + mlat) m_act = 0;
      cyc++;
   endtask

   initial begin
      int guard;
      logic [15:0] a;
      rst_n = 1'b0;
      bus.miss_detected = 1'b0;
      bus.miss_address = '0;
      bus.memory_data = '0;
      bus.memory_data_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin nxt_words[i] = '0; words[i] = '0; end

      // Reset, then idle with valid noise: nothing may move.
      clr_counts();
      tick(1'b1, 16'h1234);
      tick(1'b0, 16'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick(1'b0, 16'(i * 7));
      chk("idle_writes", 32'(n_wr), 32'd0);

      // Miss at 0x1234, latency 4, word i = 0xA000+i.
      clr_counts();
      nxt_lat = 4;
      for (int i = 0; i < 8; i++) nxt_words[i] = 16'hA000 + 16'(i);
      tick(1'b1, 16'h1234);
      while (m_act) tick(1'b0, 16'h0);
      chk("fill1_writes", 32'(n_wr), 32'd8);
      chk("fill1_tags", 32'(n_tag), 32'd1);
      chk("fill1_busy_cycles", 32'(n_busy), 32'(1 + 8 + 4));

      // Back-to-back miss at 0xFFF0, no wrap past the block.
      clr_counts();
      nxt_lat = 1;
      rand_words();
      tick(1'b1, 16'hFFF0);
      while (m_act) tick(1'b0, 16'h0);
      chk("b2b_writes", 32'(n_wr), 32'd8);
      chk("b2b_busy_cycles", 32'(n_busy), 32'(1 + 8 + 1));

      // Miss held high (with a different address) for the whole fill.
      tick(1'b0, 16'h0);
      clr_counts();
      nxt_lat = 3;
      rand_words();
      tick(1'b1, 16'h4C2A);
      while (m_act) tick(1'b1, 16'h9990);
      chk("held_miss_tags", 32'(n_tag), 32'd1);
      chk("held_miss_writes", 32'(n_wr), 32'd8);
      tick(1'b0, 16'h0);

      // Random fills with idle gaps and miss noise during the fill.
      for (int k = 0; k < 6; k++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick(1'b0, 16'h0);
         clr_counts();
         nxt_lat = int'($urandom_range(1, 6));
         rand_words();
         a = 16'($urandom);
         tick(1'b1, a);
         while (m_act) tick(1'($urandom_range(0, 1)), 16'($urandom));
         chk("rand_tags", 32'(n_tag), 32'd1);
         chk("rand_busy_cycles", 32'(n_busy), 32'(9 + nxt_lat));
      end

      // Reset after three words have been written.
      tick(1'b0, 16'h0);
      clr_counts();
      nxt_lat = 2;
      rand_words();
      tick(1'b1, 16'h2468);
      guard = 0;
      while (n_wr < 3 && guard < 40) begin tick(1'b0, 16'h0); guard++; end
      chk("reset_reached_3_words", 32'(n_wr), 32'd3);
      @(negedge clk);
      bus.miss_detected = 1'b1;
      bus.memory_data_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.fsm_busy), 32'd0);
      chk("rst_enable", 32'(bus.memory_enable), 32'd0);
      chk("rst_wdata", 32'(bus.write_data_array), 32'd0);
      chk("rst_wtag", 32'(bus.write_tag_array), 32'd0);
      chk("rst_maddr", 32'(bus.memory_address), 32'd0);
      m_act = 0;
      rq.delete();
      cyc++;
      tick(1'b1, 16'h1111);
      tick(1'b0, 16'h0);
      chk("rst_no_tag", 32'(n_tag), 32'd0);
      rst_n = 1'b1;
      clr_counts();
      nxt_lat = 5;
      rand_words();
      tick(1'b1, 16'h2468);
      while (m_act) tick(1'b0, 16'h0);
      chk("restart_writes", 32'(n_wr), 32'd8);
      chk("restart_tags", 32'(n_tag), 32'd1);
      tick(1'b0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
